// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply job launcher.
package mm_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DIM_WIDTH  = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DIM_WIDTH-1:0]  m;
    logic [DIM_WIDTH-1:0]  n;
    logic [DIM_WIDTH-1:0]  p;
  } job_desc_t;

  // A job with any zero dimension has no work for an engine.
  function automatic logic is_zero_dim(job_desc_t d);
    return (d.m == '0) || (d.n == '0) || (d.p == '0);
  endfunction

endpackage

// File: rtl/mm_job_fifo.sv
// Descriptor FIFO: first-word-fall-through head, extra pointer bit for full/empty.
module mm_job_fifo
  import mm_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = job_desc_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally through the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mm_job_dispatcher.sv
// Descriptor queue plus round-robin launcher for NUM_ENGINES matmul engines.
module mm_job_dispatcher
  import mm_pkg::*;
#(
  parameter int NUM_ENGINES = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             job_valid_i,
  input  job_desc_t                        job_desc_i,
  output logic                             job_ready_o,
  output logic [NUM_ENGINES-1:0]           eng_start_o,
  output job_desc_t [NUM_ENGINES-1:0]      eng_desc_o,
  input  logic [NUM_ENGINES-1:0]           eng_done_i,
  output logic [NUM_ENGINES-1:0]           eng_busy_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_level_o,
  output logic [15:0]                      jobs_done_o,
  output logic                             idle_o,
  output logic                             err_o,
  input  logic                             err_clr_i
);

  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  job_desc_t              head;
  logic                   full, empty, pop;
  logic                   zero_pop, dispatch, gnt_vld;
  logic [EW-1:0]          rr_ptr, gnt_idx;
  logic [NUM_ENGINES-1:0] done_ok, spurious;
  int                     cand;

  mm_job_fifo #(.DEPTH(QUEUE_DEPTH), .T(job_desc_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (job_valid_i),
    .push_data (job_desc_i),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (queue_level_o)
  );

  // Find first idle engine starting just past the last grant. With rr_ptr
  // reset to 0, the first grant after reset lands on engine 1 (if present).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_ENGINES;
      if (!gnt_vld && !eng_busy_o[cand[EW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[EW-1:0];
      end
    end
  end

  // Zero-dim jobs drain without an engine; real jobs need a grant.
  assign zero_pop = ~empty & is_zero_dim(head);
  assign dispatch = ~empty & ~is_zero_dim(head) & gnt_vld;
  assign pop      = zero_pop | dispatch;
  assign done_ok  = eng_done_i & eng_busy_o;
  assign spurious = eng_done_i & ~eng_busy_o;

  assign job_ready_o = ~full;
  assign idle_o      = empty & ~|eng_busy_o;

  // Per-engine ownership, one-cycle start pulse and held descriptor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_start_o <= '0;
      eng_busy_o  <= '0;
      eng_desc_o  <= '0;
    end else begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        eng_start_o[e] <= dispatch && (gnt_idx == EW'(e));
        if (dispatch && (gnt_idx == EW'(e))) begin
          eng_busy_o[e] <= 1'b1;
          eng_desc_o[e] <= head;
        end else if (done_ok[e]) begin
          eng_busy_o[e] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer, completion counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      jobs_done_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (dispatch) rr_ptr <= gnt_idx;
      jobs_done_o <= jobs_done_o + 16'($countones(done_ok)) + {15'd0, zero_pop};
      if (zero_pop || (|spurious)) err_o <= 1'b1;
      else if (err_clr_i)          err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mm_job_dispatcher.sv
// Scoreboarded bench for mm_job_dispatcher (2 engines, 4-deep queue).
module tb_mm_job_dispatcher;
  import mm_pkg::*;

  localparam int NE = 2;
  localparam int QD = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            job_valid = 1'b0;
  job_desc_t       job_desc = '0;
  logic            job_ready;
  logic [NE-1:0]   eng_start;
  job_desc_t [NE-1:0] eng_desc;
  logic [NE-1:0]   eng_done = '0;
  logic [NE-1:0]   eng_busy;
  logic [$clog2(QD+1)-1:0] level;
  logic [15:0]     jobs_done;
  logic            idle, err;
  logic            err_clr = 1'b0;

  typedef struct { int eng; job_desc_t d; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  mm_job_dispatcher #(.NUM_ENGINES(NE), .QUEUE_DEPTH(QD)) dut (
    .clk           (clk),
    .reset         (reset),
    .job_valid_i   (job_valid),
    .job_desc_i    (job_desc),
    .job_ready_o   (job_ready),
    .eng_start_o   (eng_start),
    .eng_desc_o    (eng_desc),
    .eng_done_i    (eng_done),
    .eng_busy_o    (eng_busy),
    .queue_level_o (level),
    .jobs_done_o   (jobs_done),
    .idle_o        (idle),
    .err_o         (err),
    .err_clr_i     (err_clr)
  );

  always #5 clk = ~clk;

  // Monitor: every start pulse must match the next expected grant.
  always @(negedge clk) begin
    if (!reset) begin
      for (int e = 0; e < NE; e++) begin
        if (eng_start[e]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL start_unexpected eng=%0d actual=1 expected=0", e);
          end else begin
            exp_t x;
            x = sb.pop_front();
            if (x.eng != e || eng_desc[e] !== x.d) begin
              failures++;
              $display("FAIL start_match eng actual=%0d expected=%0d desc actual=%0h expected=%0h",
                       e, x.eng, eng_desc[e], x.d);
            end
          end
        end
      end
    end
  end

  function automatic job_desc_t mk(input logic [15:0] id, input logic [15:0] m,
                                   input logic [15:0] n, input logic [15:0] p);
    job_desc_t d;
    d.a_addr = 16'h1000 + id;
    d.b_addr = 16'h2000 + id;
    d.c_addr = 16'h3000 + id;
    d.m = m; d.n = n; d.p = p;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_job(input job_desc_t d);
    bit ok;
    ok = 1'b0;
    job_valid = 1'b1;
    job_desc  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = job_ready;
    end
    chk("push_accept", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [NE-1:0] mask);
    eng_done = mask;
    tick();
    eng_done = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    job_valid = 1'b0;
    eng_done  = '0;
    err_clr   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Reset values
    chk("rst_ready", job_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", eng_busy, 0);
    chk("rst_level", level, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_err", err, 0);
    chk("rst_desc_zero", {63'd0, eng_desc == '0}, 1);

    // 1: single job, first grant goes to engine 1 (search starts past rr_ptr=0)
    sb.push_back('{1, mk(1, 4, 4, 4)});
    push_job(mk(1, 4, 4, 4));
    chk("t1_level_after_push", level, 1);
    chk("t1_no_start_yet", eng_start, 0);
    tick();
    chk("t1_start", eng_start, 2'b10);
    chk("t1_busy", eng_busy, 2'b10);
    chk("t1_idle", idle, 0);
    chk("t1_level", level, 0);
    tick();
    chk("t1_start_one_cycle", eng_start, 0);
    drain("t1_drain");

    // 2: six back-to-back pushes with engines never finishing
    do_reset();
    sb.push_back('{1, mk(11, 2, 3, 4)});
    sb.push_back('{0, mk(12, 2, 3, 4)});
    sb.push_back('{1, mk(13, 2, 3, 4)});
    for (int i = 1; i <= 6; i++) push_job(mk(16'(10 + i), 2, 3, 4));
    chk("t2_level_full", level, 4);
    chk("t2_ready_low", job_ready, 0);
    chk("t2_busy", eng_busy, 2'b11);
    fork
      push_job(mk(17, 2, 3, 4));
      begin
        repeat (3) tick();
        chk("t2_stall_level", level, 4);
        chk("t2_stall_ready", job_ready, 0);
        pulse_done(2'b10);
      end
    join
    chk("t2_level_after_7th", level, 4);
    chk("t2_jobs", jobs_done, 1);
    chk("t2_busy_after", eng_busy, 2'b11);
    drain("t2_drain");

    // 3: round-robin alternation with engines freed between jobs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int e;
      e = (i % 2 == 0) ? 1 : 0;
      sb.push_back('{e, mk(16'(20 + i), 8, 8, 8)});
      push_job(mk(16'(20 + i), 8, 8, 8));
      tick();
      chk("t3_busy", eng_busy, 64'(1 << e));
      pulse_done(NE'(1 << e));
    end
    chk("t3_jobs", jobs_done, 4);
    chk("t3_idle", idle, 1);
    drain("t3_drain");

    // 4: zero-dimension job
    push_job(mk(30, 5, 0, 5));
    tick();
    chk("t4_jobs", jobs_done, 5);
    chk("t4_err", err, 1);
    chk("t4_busy", eng_busy, 0);
    chk("t4_level", level, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_err_clr", err, 0);

    // 5: dual completion, zero-dim while busy, spurious done, clear vs new error
    sb.push_back('{1, mk(40, 1, 1, 1)});
    sb.push_back('{0, mk(41, 1, 1, 1)});
    push_job(mk(40, 1, 1, 1));
    push_job(mk(41, 1, 1, 1));
    tick();
    chk("t5_busy", eng_busy, 2'b11);
    push_job(mk(42, 0, 7, 7));
    tick();
    chk("t5_zero_busy_jobs", jobs_done, 6);
    chk("t5_zero_busy_err", err, 1);
    chk("t5_zero_busy_level", level, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_err_clr", err, 0);
    pulse_done(2'b11);
    chk("t5_jobs_plus2", jobs_done, 8);
    chk("t5_busy_free", eng_busy, 0);
    pulse_done(2'b01);
    chk("t5_spurious_err", err, 1);
    chk("t5_spurious_jobs", jobs_done, 8);
    err_clr = 1'b1; eng_done = 2'b10; tick(); err_clr = 1'b0; eng_done = '0;
    chk("t5_err_wins", err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_err_clr2", err, 0);
    drain("t5_drain");

    // 6: asynchronous reset with 3 queued and 2 busy
    sb.push_back('{1, mk(50, 3, 3, 3)});
    sb.push_back('{0, mk(51, 3, 3, 3)});
    for (int i = 0; i < 5; i++) push_job(mk(16'(50 + i), 3, 3, 3));
    chk("t6_level", level, 3);
    chk("t6_busy", eng_busy, 2'b11);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_async_level", level, 0);
    chk("t6_async_busy", eng_busy, 0);
    chk("t6_async_ready", job_ready, 1);
    chk("t6_async_idle", idle, 1);
    chk("t6_async_jobs", jobs_done, 0);
    chk("t6_async_desc_zero", {63'd0, eng_desc == '0}, 1);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_post_idle", idle, 1);
    chk("t6_post_busy", eng_busy, 0);
    sb.push_back('{1, mk(60, 2, 2, 2)});
    push_job(mk(60, 2, 2, 2));
    tick();
    chk("t6_new_start", eng_start, 2'b10);
    drain("t6_drain");

    // Counter wrap via a stream of zero-dim jobs
    do_reset();
    job_desc  = mk(70, 0, 0, 0);
    job_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 job_valid = 1'b0;
    tick(); tick();
    chk("wrap_ffff", jobs_done, 16'hFFFF);
    push_job(mk(71, 0, 1, 1));
    tick();
    chk("wrap_zero", jobs_done, 0);
    chk("wrap_err", err, 1);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
